// File: rtl/icepic_run_ctrl.sv
// Run/debug controller for the icepic_12 core: one registered clock-enable
// sequencing power-up hold, free-run, halt, single-step and breakpoint stops.
module icepic_run_ctrl #(
    parameter int RESET_HOLD_CYCLES = 4,
    parameter bit START_HALTED      = 1'b0
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        halt_req_in,
    input  logic        resume_req_in,
    input  logic        step_req_in,
    input  logic        bp_en_in,
    input  logic [11:0] bp_addr_in,
    input  logic [11:0] pc_in,
    input  logic        invalidate_in,
    output logic        core_en_out,
    output logic        halted_out,
    output logic        bp_hit_out,
    output logic [15:0] exec_cnt_out,
    output logic [2:0]  dbg_state_out
);

    typedef enum logic [2:0] {
        S_HOLD   = 3'd0,
        S_RUN    = 3'd1,
        S_DRAIN  = 3'd2,
        S_HALTED = 3'd3,
        S_STEP   = 3'd4
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(RESET_HOLD_CYCLES - 1);

    state_t      r_state;
    logic [7:0]  r_hold_cnt;
    logic        r_core_en;
    logic        r_halted;
    logic        r_bp_hit;
    logic        r_bp_mask;
    logic [15:0] r_exec_cnt;

    logic w_bp_match;
    logic w_stop;

    // The mask suppresses the breakpoint for the first RUN cycle after a
    // resume, so resuming at the breakpoint address makes forward progress.
    assign w_bp_match = bp_en_in && (pc_in == bp_addr_in) && !r_bp_mask;
    assign w_stop     = halt_req_in || w_bp_match;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_state    <= S_HOLD;
            r_hold_cnt <= 8'd0;
            r_core_en  <= 1'b0;
            r_halted   <= 1'b0;
            r_bp_hit   <= 1'b0;
            r_bp_mask  <= 1'b0;
            r_exec_cnt <= 16'd0;
        end else begin
            r_bp_mask <= 1'b0;
            if (r_core_en) begin
                r_exec_cnt <= r_exec_cnt + 16'd1;
            end
            case (r_state)
                S_HOLD: begin
                    r_hold_cnt <= r_hold_cnt + 8'd1;
                    if (r_hold_cnt == HOLD_LAST) begin
                        r_hold_cnt <= 8'd0;
                        if (START_HALTED) begin
                            r_state  <= S_HALTED;
                            r_halted <= 1'b1;
                        end else begin
                            r_state   <= S_RUN;
                            r_core_en <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_stop) begin
                        if (w_bp_match) begin
                            r_bp_hit <= 1'b1;
                        end
                        // A stop during a flush lets the flush finish first.
                        if (invalidate_in) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_state   <= S_HALTED;
                            r_core_en <= 1'b0;
                            r_halted  <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!invalidate_in) begin
                        r_state   <= S_HALTED;
                        r_core_en <= 1'b0;
                        r_halted  <= 1'b1;
                    end
                end
                S_HALTED: begin
                    if (step_req_in) begin
                        r_state   <= S_STEP;
                        r_core_en <= 1'b1;
                        r_halted  <= 1'b0;
                    end else if (resume_req_in && !halt_req_in) begin
                        r_state   <= S_RUN;
                        r_core_en <= 1'b1;
                        r_halted  <= 1'b0;
                        r_bp_hit  <= 1'b0;
                        r_bp_mask <= 1'b1;
                    end
                end
                S_STEP: begin
                    if (invalidate_in) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_state   <= S_HALTED;
                        r_core_en <= 1'b0;
                        r_halted  <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_HOLD;
                    r_core_en <= 1'b0;
                    r_halted  <= 1'b0;
                end
            endcase
        end
    end

    assign core_en_out   = r_core_en;
    assign halted_out    = r_halted;
    assign bp_hit_out    = r_bp_hit;
    assign exec_cnt_out  = r_exec_cnt;
    assign dbg_state_out = r_state;

endmodule

// File: tb/tb_icepic_run_ctrl.sv
// Directed bench for icepic_run_ctrl: expected {core_en, halted, bp_hit, exec_cnt}
// words are queued per step and compared one edge later.
module tb_icepic_run_ctrl;

    logic        clk_in = 1'b0;
    logic        reset_in = 1'b1;
    logic        halt_req_in = 1'b0;
    logic        resume_req_in = 1'b0;
    logic        step_req_in = 1'b0;
    logic        bp_en_in = 1'b0;
    logic [11:0] bp_addr_in = 12'h000;
    logic [11:0] pc_in = 12'h000;
    logic        invalidate_in = 1'b0;
    logic        core_en_out;
    logic        halted_out;
    logic        bp_hit_out;
    logic [15:0] exec_cnt_out;
    logic [2:0]  dbg_state_out;

    icepic_run_ctrl #(
        .RESET_HOLD_CYCLES(4),
        .START_HALTED(1'b0)
    ) dut (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .halt_req_in  (halt_req_in),
        .resume_req_in(resume_req_in),
        .step_req_in  (step_req_in),
        .bp_en_in     (bp_en_in),
        .bp_addr_in   (bp_addr_in),
        .pc_in        (pc_in),
        .invalidate_in(invalidate_in),
        .core_en_out  (core_en_out),
        .halted_out   (halted_out),
        .bp_hit_out   (bp_hit_out),
        .exec_cnt_out (exec_cnt_out),
        .dbg_state_out(dbg_state_out)
    );

    always #5 clk_in = ~clk_in;

    logic [18:0] exp_q[$];
    string       tag_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        m_en  = 1'b0;
    logic [15:0] m_cnt = 16'd0;

    task automatic compare_head();
        logic [18:0] exp_v;
        logic [18:0] obs_v;
        string       tag;
        exp_v = exp_q.pop_front();
        tag   = tag_q.pop_front();
        obs_v = {core_en_out, halted_out, bp_hit_out, exec_cnt_out};
        checks++;
        assert (obs_v === exp_v) else begin
            errors++;
            $error("FAIL %s observed en/hlt/bp/cnt=%b/%b/%b/%h expected=%b/%b/%b/%h", tag,
                   obs_v[18], obs_v[17], obs_v[16], obs_v[15:0],
                   exp_v[18], exp_v[17], exp_v[16], exp_v[15:0]);
        end
    endtask

    // One clock edge; the counter model advances when the enable expected
    // during the preceding cycle was high.
    task automatic tick(input logic e_en, input logic e_halt, input logic e_bp, input string tag);
        if (m_en) m_cnt = m_cnt + 16'd1;
        exp_q.push_back({e_en, e_halt, e_bp, m_cnt});
        tag_q.push_back(tag);
        @(posedge clk_in); #1;
        compare_head();
        m_en = e_en;
    endtask

    task automatic reset_tick(input string tag);
        reset_in = 1'b1;
        m_en  = 1'b0;
        m_cnt = 16'd0;
        exp_q.push_back(19'd0);
        tag_q.push_back(tag);
        @(posedge clk_in); #1;
        compare_head();
        reset_in = 1'b0;
    endtask

    initial begin
        // Reset and power-up hold: enable rises after the 4th edge
        @(posedge clk_in); #1;
        reset_tick("reset");
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, "hold");
        tick(1'b1, 1'b0, 1'b0, "hold_exit");
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, "run");

        // Plain halt, resume ignored while halt held, then resume
        halt_req_in = 1'b1;
        tick(1'b0, 1'b1, 1'b0, "halt_enter");
        tick(1'b0, 1'b1, 1'b0, "halt_frozen");
        resume_req_in = 1'b1;
        tick(1'b0, 1'b1, 1'b0, "resume_ignored");
        resume_req_in = 1'b0;
        halt_req_in   = 1'b0;
        tick(1'b0, 1'b1, 1'b0, "halt_idle");
        resume_req_in = 1'b1;
        tick(1'b1, 1'b0, 1'b0, "resume");
        resume_req_in = 1'b0;
        step_req_in   = 1'b1;
        tick(1'b1, 1'b0, 1'b0, "step_in_run");
        step_req_in = 1'b0;
        tick(1'b1, 1'b0, 1'b0, "run_after_resume");

        // Breakpoint at 0x023, resume past it, hit it again
        bp_en_in   = 1'b1;
        bp_addr_in = 12'h023;
        pc_in = 12'h021;
        tick(1'b1, 1'b0, 1'b0, "bp_pc21");
        pc_in = 12'h022;
        tick(1'b1, 1'b0, 1'b0, "bp_pc22");
        pc_in = 12'h023;
        tick(1'b0, 1'b1, 1'b1, "bp_hit");
        tick(1'b0, 1'b1, 1'b1, "bp_hold");
        resume_req_in = 1'b1;
        tick(1'b1, 1'b0, 1'b0, "bp_resume");
        resume_req_in = 1'b0;
        tick(1'b1, 1'b0, 1'b0, "bp_masked");
        pc_in = 12'h024;
        tick(1'b1, 1'b0, 1'b0, "bp_pc24");
        pc_in = 12'h025;
        tick(1'b1, 1'b0, 1'b0, "bp_pc25");
        pc_in = 12'h023;
        tick(1'b0, 1'b1, 1'b1, "bp_rehit");
        bp_en_in = 1'b0;
        resume_req_in = 1'b1;
        tick(1'b1, 1'b0, 1'b0, "bp_clear_resume");
        resume_req_in = 1'b0;

        // Halt during a flush: two more enabled cycles, then HALTED
        halt_req_in   = 1'b1;
        invalidate_in = 1'b1;
        tick(1'b1, 1'b0, 1'b0, "drain_enter");
        halt_req_in = 1'b0;
        tick(1'b1, 1'b0, 1'b0, "drain_hold");
        invalidate_in = 1'b0;
        tick(1'b0, 1'b1, 1'b0, "drain_exit");

        // Three spaced single steps
        for (int i = 0; i < 3; i++) begin
            step_req_in = 1'b1;
            tick(1'b1, 1'b0, 1'b0, "step_en");
            step_req_in = 1'b0;
            tick(1'b0, 1'b1, 1'b0, "step_done");
            tick(1'b0, 1'b1, 1'b0, "step_gap");
        end
        // Step and resume together: step wins
        step_req_in   = 1'b1;
        resume_req_in = 1'b1;
        tick(1'b1, 1'b0, 1'b0, "step_resume_en");
        step_req_in   = 1'b0;
        resume_req_in = 1'b0;
        tick(1'b0, 1'b1, 1'b0, "step_resume_halted");
        tick(1'b0, 1'b1, 1'b0, "step_resume_stay");
        // Step with halt held, landing on a flush
        halt_req_in = 1'b1;
        step_req_in = 1'b1;
        tick(1'b1, 1'b0, 1'b0, "step_halt_held");
        step_req_in   = 1'b0;
        invalidate_in = 1'b1;
        tick(1'b1, 1'b0, 1'b0, "step_to_drain");
        invalidate_in = 1'b0;
        tick(1'b0, 1'b1, 1'b0, "step_drain_exit");
        halt_req_in = 1'b0;

        // Counter wrap
        resume_req_in = 1'b1;
        tick(1'b1, 1'b0, 1'b0, "wrap_resume");
        resume_req_in = 1'b0;
        while (m_cnt != 16'hFFFE) begin
            @(posedge clk_in);
            m_cnt = m_cnt + 16'd1;
        end
        #1;
        tick(1'b1, 1'b0, 1'b0, "wrap_ffff");
        tick(1'b1, 1'b0, 1'b0, "wrap_0000");

        // Reset during STEP restarts the hold
        halt_req_in = 1'b1;
        tick(1'b0, 1'b1, 1'b0, "pre_step_halt");
        halt_req_in = 1'b0;
        step_req_in = 1'b1;
        tick(1'b1, 1'b0, 1'b0, "pre_reset_step");
        step_req_in = 1'b0;
        reset_tick("reset_in_step");
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, "rehold");
        tick(1'b1, 1'b0, 1'b0, "rehold_exit");
        tick(1'b1, 1'b0, 1'b0, "rerun");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/icepic_run_ctrl.md
Name: icepic_run_ctrl

Overview:
Run/debug controller for the icepic_12 core. It generates a single registered clock-enable that gates every core flop: PC, fetch and decode registers, W, file register and stack. It sequences the power-up hold, free-run, halt, single-step and breakpoint stops. It defers any stop while the pipeline is flushing a taken branch or skip, so a halt never freezes the core mid-flush.

Parameters:
RESET_HOLD_CYCLES, 4, number of cycles core_en_out stays low after reset before leaving HOLD (range 1..255).
START_HALTED, 0, 1 = leave HOLD into HALTED instead of RUN.

Ports:
clk_in  input  1  system clock
reset_in  input  1  synchronous, active-high reset
halt_req_in  input  1  level; request stop
resume_req_in  input  1  one-cycle pulse; leave HALTED
step_req_in  input  1  one-cycle pulse; advance core one enabled cycle
bp_en_in  input  1  breakpoint enable
bp_addr_in  input  12  breakpoint address
pc_in  input  12  core next-fetch address (inst_addr)
invalidate_in  input  1  core pipeline-flush indicator (invalidate_op)
core_en_out  output  1  registered clock-enable to all core state
halted_out  output  1  registered; core frozen and stable
bp_hit_out  output  1  sticky; last stop was caused by breakpoint
exec_cnt_out  output  16  count of enabled core cycles

Behaviour:
- Clock and reset: one clock, clk_in. reset_in is synchronous and active-high. All state changes on the posedge of clk_in.
- All outputs are registered. On reset: state=HOLD, core_en_out=0, halted_out=0, bp_hit_out=0, exec_cnt_out=0, hold counter=0.
- Reset mid-operation (any state, including STEP or DRAIN) aborts to HOLD with the reset values above.
- States: HOLD, RUN, DRAIN, HALTED, STEP.
- bp_match = bp_en_in && pc_in==bp_addr_in && !bp_mask. bp_mask is a 1-cycle flag set on entry to RUN from HALTED, so a resume at the breakpoint address does not re-stop at once.
- stop_cond = halt_req_in || bp_match.

State transitions:
- HOLD: counter increments each cycle. When counter==RESET_HOLD_CYCLES-1, go to HALTED if START_HALTED=1, else to RUN. core_en_out=0 throughout.
- RUN: core_en_out=1.
  - stop_cond && !invalidate_in -> HALTED.
  - stop_cond && invalidate_in -> DRAIN.
  - bp_hit_out is set to 1 on the same edge if bp_match caused the stop.
- DRAIN: core_en_out=1. Stays in DRAIN while invalidate_in=1; goes to HALTED on the first cycle with invalidate_in=0. DRAIN completes even if halt_req_in drops.
- HALTED: core_en_out=0, halted_out=1.
  - step_req_in -> STEP.
  - Otherwise resume_req_in && !halt_req_in -> RUN; this clears bp_hit_out and sets bp_mask.
  - If step and resume arrive in the same cycle, step wins.
  - resume_req_in while halt_req_in=1 is ignored.
- STEP: exactly one cycle with core_en_out=1, breakpoint ignored. Next state is DRAIN if invalidate_in=1, else HALTED.

Latency:
- A stop_cond sampled at edge E drives core_en_out=0 from E onward. The core still advances at E because core_en_out was 1 during the preceding cycle.
- On a breakpoint stop, the instruction at bp_addr_in is fetched and not yet executed. pc_fetch equals bp_addr_in.
- halted_out rises on the same edge that core_en_out falls when entering HALTED. In DRAIN, halted_out rises only when DRAIN exits.

Counter:
- exec_cnt_out increments on every edge where core_en_out=1.
- Wraps from 16'hFFFF to 16'h0000. Cleared only by reset.

Other rules:
- step_req_in and resume_req_in outside HALTED are ignored and are not queued.
- halt_req_in held high keeps the controller in HALTED; steps are still allowed.

Test Plan:
- Reset, RESET_HOLD_CYCLES=4, START_HALTED=0 -> core_en_out=0 for 4 cycles, then 1. exec_cnt_out starts counting on the 5th edge after reset release.
- In RUN with invalidate_in=0, pulse halt_req_in=1 at cycle N -> core_en_out=0 and halted_out=1 from N+1. exec_cnt_out freezes. Drop halt_req_in and pulse resume_req_in -> core_en_out=1 next cycle.
- bp_en_in=1, bp_addr_in=12'h023, pc_in steps 21,22,23 -> halt with pc_in=12'h023 and bp_hit_out=1. Resume -> no immediate re-stop, bp_hit_out=0. Next time pc_in=12'h023 -> stops again.
- Halt while invalidate_in=1 for 2 cycles -> DRAIN keeps core_en_out=1 for 2 more cycles, then HALTED. halted_out stays 0 until exit.
- In HALTED, three step_req_in pulses spaced 3 cycles apart -> core_en_out high for exactly one cycle each. exec_cnt_out advances by 3. Step and resume pulsed together -> single step, remain HALTED.
- Preload exec_cnt_out to 16'hFFFE via run time, run 2 cycles -> 16'h0000. Assert reset_in during STEP -> all outputs at reset values next cycle, HOLD restarts.
